// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipelined DFF bank.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the bank: data plus valid bit with clear/flush.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             flush,
  input  logic             rdy,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] d,
  output logic             v
);

  logic [WIDTH-1:0] d_q, d_d;
  logic             v_q, v_d;

  // Clear beats flush beats normal flow; flush keeps data to save toggling.
  always_comb begin
    d_d = d_q;
    v_d = v_q;
    if (clr) begin
      v_d = 1'b0;
      d_d = RST_VAL;
    end else if (flush) begin
      v_d = 1'b0;
    end else if (rdy) begin
      v_d = src_valid;
      if (src_valid) d_d = src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RST_VAL;
      v_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  assign d = d_q;
  assign v = v_q;

endmodule

// File: rtl/pipe_dff_bank.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing and an
// occupancy counter.
module pipe_dff_bank
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         C,
  input  logic                         R_N,
  input  logic                         CLR,
  input  logic                         FLUSH,
  input  logic                         IN_VALID,
  input  logic [WIDTH-1:0]             IN_DATA,
  output logic                         IN_READY,
  output logic                         OUT_VALID,
  output logic [WIDTH-1:0]             OUT_DATA,
  input  logic                         OUT_READY,
  output logic [clog2(DEPTH+1)-1:0]    OCC
);

  localparam int OCC_W = clog2(DEPTH + 1);

  // Handshake: a beat transfers on a posedge C where VALID and READY are both
  // high on that side; READY never depends combinationally on IN_VALID.
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  // A stage can take new data if it is empty or its successor is moving.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = OUT_READY;
    for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = ~v[k] | rdy[k+1];
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = IN_VALID;
    src_d[0] = IN_DATA;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk       (C),
      .rst_n     (R_N),
      .clr       (CLR),
      .flush     (FLUSH),
      .rdy       (rdy[k]),
      .src_valid (src_v[k]),
      .src_data  (src_d[k]),
      .d         (d[k]),
      .v         (v[k])
    );
  end

  logic             in_xfer, out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_xfer  = IN_VALID & rdy[0];
  assign out_xfer = v[DEPTH-1] & OUT_READY;

  always_comb begin
    occ_d = occ_q;
    if (CLR || FLUSH)            occ_d = '0;
    else if (in_xfer && !out_xfer) occ_d = occ_q + OCC_W'(1);
    else if (!in_xfer && out_xfer) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign IN_READY  = rdy[0];
  assign OUT_VALID = v[DEPTH-1];
  assign OUT_DATA  = d[DEPTH-1];
  assign OCC       = occ_q;

endmodule

// File: doc/pipe_dff_bank.md
PIPE_DFF_BANK -- requirements
Module: pipe_dff_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage; WIDTH >= 1.
REQ-002 Parameter DEPTH, default 4: number of register stages; DEPTH >= 1.
REQ-003 Parameter RST_VAL, default all-zeros, WIDTH bits: data value loaded by reset and by CLR.
REQ-004 Port C, input, 1: single clock; all state changes on posedge C.
REQ-005 Port R_N, input, 1: reset, asynchronous, active-low.
REQ-006 Port CLR, input, 1: synchronous clear of data and valid bits.
REQ-007 Port FLUSH, input, 1: synchronous invalidate; data left unchanged.
REQ-008 Port IN_VALID, input, 1: upstream offers IN_DATA.
REQ-009 Port IN_DATA, input, WIDTH: upstream data.
REQ-010 Port IN_READY, output, 1: bank accepts IN_DATA this cycle.
REQ-011 Port OUT_VALID, output, 1: OUT_DATA valid.
REQ-012 Port OUT_DATA, output, WIDTH: data of last stage.
REQ-013 Port OUT_READY, input, 1: downstream accepts OUT_DATA.
REQ-014 Port OCC, output, clog2(DEPTH+1): count of valid stages.

Function
REQ-015 Stage k (0..DEPTH-1) SHALL hold data d[k] and valid v[k]; OUT_DATA = d[DEPTH-1], OUT_VALID = v[DEPTH-1].
REQ-016 rdy[DEPTH] = OUT_READY; rdy[k] = ~v[k] | rdy[k+1]; IN_READY = rdy[0], combinational, no combinational path from IN_VALID.
REQ-017 When rdy[k], stage k SHALL load v[k] <= source valid (IN_VALID for k=0, else v[k-1]); d[k] loads source data only when source valid, else holds.
REQ-018 When ~rdy[k], stage k SHALL hold d[k] and v[k] (stall).
REQ-019 Bubbles SHALL collapse: a valid item advances into any invalid downstream stage even while OUT_READY=0.
REQ-020 Latency: item accepted at edge t into empty bank SHALL present OUT_VALID=1 after edge t+DEPTH-1 (DEPTH cycles input-to-output).
REQ-021 Throughput: with OUT_READY held 1, one item per cycle, IN_READY constantly 1.
REQ-022 Transfer occurs on an edge where VALID & READY on the respective side; items SHALL exit in arrival order, none duplicated or lost.
REQ-023 OCC SHALL equal the number of set v[k], updated as a registered counter: +1 on input transfer, -1 on output transfer, unchanged when both or neither.
REQ-024 FLUSH=1: all v[k] <= 0, d[k] hold, OCC <= 0; an input offered that cycle is dropped; an output transfer that cycle still completes.
REQ-025 CLR=1: all v[k] <= 0, all d[k] <= RST_VAL, OCC <= 0; CLR has priority over FLUSH; both over normal flow.
REQ-026 DEPTH=1: single stage, rdy[0] = ~v[0] | OUT_READY; all other rules unchanged.

Reset
REQ-027 R_N=0 SHALL immediately, independent of C, force all v[k]=0, all d[k]=RST_VAL, OCC=0, hence OUT_VALID=0, OUT_DATA=RST_VAL, IN_READY=1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight items; none appear after release.
REQ-029 First edge after R_N rises SHALL behave as normal operation from empty.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the clog2 function and default WIDTH/DEPTH constants.
REQ-031 One sub-module pipe_stage (one stage: d, v, load/hold, CLR/FLUSH, async reset) SHALL be instantiated DEPTH times via generate; pipe_dff_bank holds the rdy chain and OCC counter.

Verification (WIDTH=8, DEPTH=4, RST_VAL=0)
REQ-032 Reset then stream 0x01..0x08, OUT_READY=1 -> first OUT_VALID 4 cycles after first accept, outputs 0x01..0x08 in order, IN_READY stays 1, OCC peaks at 4.
REQ-033 OUT_READY=0, push 0xA0..0xA5 -> 4 accepted, IN_READY=0 with OCC=4; raise OUT_READY -> 0xA0..0xA3 exit, one per cycle.
REQ-034 Push 0x11, idle 2 cycles, push 0x22, OUT_READY=0 -> bubbles collapse, OCC=2, v[3:2]=11, output 0x11 then 0x22.
REQ-035 OCC=3, assert FLUSH with IN_VALID=1 (0x55), OUT_READY=1 -> next cycle OCC=0, OUT_VALID=0, 0x55 never emitted; CLR same case -> all d=0x00.
REQ-036 OCC=4, drop R_N between edges -> OUT_VALID=0, OUT_DATA=0x00 immediately; after release, push 0x77 -> only 0x77 emitted.
